// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS-subset pipeline: ALU operation codes,
// ALUOp encodings, R-type funct values and the execute-stage control bundle.
package mips_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_NOR = 4'b1100;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_ORI   = 2'b11;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_NOR = 6'b100111;

  // Architectural register-address width carried inside the control bundle.
  localparam int WREG_W = 5;

  typedef struct packed {
    logic              regwrite;
    logic              memread;
    logic              memwrite;
    logic              branch;
    logic              illegal;
    logic [WREG_W-1:0] wreg;
  } ex_ctrl_t;

endpackage

// File: rtl/alu_control.sv
// Combinational ALUOp/funct decoder producing the 4-bit ALU operation code
// and an illegal flag for unsupported R-type funct values.
module alu_control
  import mips_pkg::*;
(
  input  logic [1:0] i_aluop,
  input  logic [5:0] i_funct,
  output logic [3:0] o_operation,
  output logic       o_illegal
);

  always_comb begin
    o_operation = ALU_ADD;
    o_illegal   = 1'b0;
    case (i_aluop)
      ALUOP_ADD: o_operation = ALU_ADD;
      ALUOP_SUB: o_operation = ALU_SUB;
      ALUOP_ORI: o_operation = ALU_OR;
      default: begin
        case (i_funct)
          FN_ADD:  o_operation = ALU_ADD;
          FN_SUB:  o_operation = ALU_SUB;
          FN_AND:  o_operation = ALU_AND;
          FN_OR:   o_operation = ALU_OR;
          FN_SLT:  o_operation = ALU_SLT;
          FN_NOR:  o_operation = ALU_NOR;
          // Unknown funct still executes as ADD so the pipe keeps flowing.
          default: o_illegal   = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ID/EX register (S1) feeding an external ALU, and EX/MEM
// register (S2) capturing result, branch decision and pass-through control.
module ex_stage
  import mips_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        in_aluop,
  input  logic [5:0]        in_funct,
  input  logic [XLEN-1:0]   in_rs_val,
  input  logic [XLEN-1:0]   in_rt_val,
  input  logic [XLEN-1:0]   in_imm,
  input  logic [XLEN-1:0]   in_pc4,
  input  logic              in_alusrc,
  input  logic [REG_AW-1:0] in_wreg,
  input  logic              in_regwrite,
  input  logic              in_memread,
  input  logic              in_memwrite,
  input  logic              in_branch,
  output logic [3:0]        alu_operation,
  output logic [XLEN-1:0]   alu_a,
  output logic [XLEN-1:0]   alu_b,
  input  logic [XLEN-1:0]   alu_result,
  input  logic              alu_zero,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   out_result,
  output logic [XLEN-1:0]   out_store_data,
  output logic [XLEN-1:0]   out_br_target,
  output logic [REG_AW-1:0] out_wreg,
  output logic              out_regwrite,
  output logic              out_memread,
  output logic              out_memwrite,
  output logic              out_br_taken,
  output logic              out_illegal
);

  logic            w_s2_adv;
  logic            w_s1_to_s2;
  logic            w_accept;
  logic [3:0]      w_op;
  logic            w_illegal;
  ex_ctrl_t        w_ctrl;

  logic            r_vld_p1;
  logic [3:0]      r_op_p1;
  logic [XLEN-1:0] r_a_p1;
  logic [XLEN-1:0] r_b_p1;
  logic [XLEN-1:0] r_rt_p1;
  logic [XLEN-1:0] r_imm_p1;
  logic [XLEN-1:0] r_pc4_p1;
  ex_ctrl_t        r_ctrl_p1;

  logic            r_vld_p2;
  logic [XLEN-1:0] r_result_p2;
  logic [XLEN-1:0] r_store_p2;
  logic [XLEN-1:0] r_target_p2;
  logic            r_taken_p2;
  ex_ctrl_t        r_ctrl_p2;

  alu_control u_alu_control (
    .i_aluop     (in_aluop),
    .i_funct     (in_funct),
    .o_operation (w_op),
    .o_illegal   (w_illegal)
  );

  assign w_s2_adv   = !r_vld_p2 || out_ready;
  assign w_s1_to_s2 = r_vld_p1 && w_s2_adv;
  assign in_ready   = !r_vld_p1 || w_s1_to_s2;
  assign w_accept   = in_valid && in_ready;

  always_comb begin
    w_ctrl          = '0;
    w_ctrl.regwrite = in_regwrite;
    w_ctrl.memread  = in_memread;
    w_ctrl.memwrite = in_memwrite;
    w_ctrl.branch   = in_branch;
    w_ctrl.illegal  = w_illegal;
    w_ctrl.wreg     = WREG_W'(in_wreg);
  end

  // ---- S1: ID/EX register, drives the ALU directly ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1  <= 1'b0;
      r_op_p1   <= '0;
      r_a_p1    <= '0;
      r_b_p1    <= '0;
      r_rt_p1   <= '0;
      r_imm_p1  <= '0;
      r_pc4_p1  <= '0;
      r_ctrl_p1 <= '0;
    end else if (flush) begin
      r_vld_p1  <= 1'b0;
    end else begin
      if (in_ready) r_vld_p1 <= in_valid;
      if (w_accept) begin
        r_op_p1   <= w_op;
        r_a_p1    <= in_rs_val;
        r_b_p1    <= in_alusrc ? in_imm : in_rt_val;
        r_rt_p1   <= in_rt_val;
        r_imm_p1  <= in_imm;
        r_pc4_p1  <= in_pc4;
        r_ctrl_p1 <= w_ctrl;
      end
    end
  end

  assign alu_operation = r_op_p1;
  assign alu_a         = r_a_p1;
  assign alu_b         = r_b_p1;

  // ---- S2: EX/MEM register, holds while MEM back-pressures ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2    <= 1'b0;
      r_result_p2 <= '0;
      r_store_p2  <= '0;
      r_target_p2 <= '0;
      r_taken_p2  <= 1'b0;
      r_ctrl_p2   <= '0;
    end else if (flush) begin
      r_vld_p2    <= 1'b0;
    end else begin
      if (w_s2_adv) r_vld_p2 <= r_vld_p1;
      if (w_s1_to_s2) begin
        r_result_p2 <= alu_result;
        r_store_p2  <= r_rt_p1;
        r_target_p2 <= r_pc4_p1 + (r_imm_p1 << 2);
        r_taken_p2  <= r_ctrl_p1.branch & alu_zero;
        r_ctrl_p2   <= r_ctrl_p1;
      end
    end
  end

  assign out_valid      = r_vld_p2;
  assign out_result     = r_result_p2;
  assign out_store_data = r_store_p2;
  assign out_br_target  = r_target_p2;
  assign out_br_taken   = r_taken_p2;
  assign out_wreg       = REG_AW'(r_ctrl_p2.wreg);
  assign out_regwrite   = r_ctrl_p2.regwrite;
  assign out_memread    = r_ctrl_p2.memread;
  assign out_memwrite   = r_ctrl_p2.memwrite;
  assign out_illegal    = r_ctrl_p2.illegal;

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute-stage wrapper for the 5-stage MIPS-subset pipeline. It holds the ID/EX register and translates ALUOp/funct into the 4-bit ALU operation code. It drives the combinational ALU and captures the ALU result, zero flag, branch decision and pass-through control into the EX/MEM register. Both stage boundaries use valid/ready handshakes, so the block supports back-pressure from MEM and flush from branch resolution.

## Interface
Parameters:
- `XLEN`, 32: datapath width.
- `REG_AW`, 5: register-address width.

Ports:
- `clk`  in  1  rising-edge clock; single clock domain.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous squash of both internal stages.
- `in_valid`  in  1  ID presents an instruction.
- `in_ready`  out  1  ex_stage accepts this cycle.
- `in_aluop`  in  2  00 add, 01 sub, 10 R-type (use funct), 11 or-immediate.
- `in_funct`  in  6  R-type funct field.
- `in_rs_val`, `in_rt_val`, `in_imm`, `in_pc4`  in  XLEN each  operands, sign-extended immediate, PC+4.
- `in_alusrc`  in  1  when 1, operand B is `in_imm`; otherwise `in_rt_val`.
- `in_wreg`  in  REG_AW  destination register.
- `in_regwrite`, `in_memread`, `in_memwrite`, `in_branch`  in  1 each  control bits.
- `alu_operation`  out  4  to ALU.
- `alu_a`, `alu_b`  out  XLEN  to ALU.
- `alu_result`  in  XLEN  from ALU.
- `alu_zero`  in  1  from ALU.
- `out_valid`  out  1  EX/MEM entry valid.
- `out_ready`  in  1  MEM accepts.
- `out_result`, `out_store_data`, `out_br_target`  out  XLEN  registered results.
- `out_wreg`  out  REG_AW  registered destination register.
- `out_regwrite`, `out_memread`, `out_memwrite`, `out_br_taken`, `out_illegal`  out  1 each  registered control and status.

## Operation
- ALU op codes: AND 0000, OR 0001, ADD 0010, SUB 0110, SLT 0111, NOR 1100.
- ALU control decode:
  - aluop 00 → ADD.
  - aluop 01 → SUB.
  - aluop 11 → OR.
  - aluop 10 uses funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT, 100111 NOR.
  - Any other funct → ADD, with `illegal`=1 carried to `out_illegal`.
- Decode happens at ID/EX capture. The code is stored in the S1 register, so `alu_operation` is a register output.
- S1 (ID/EX) holds the operands, the decoded op, B = alusrc ? imm : rt_val, the control bits and pc4. `alu_a`/`alu_b`/`alu_operation` come straight from S1.
- S2 (EX/MEM) captures on S1→S2 transfer:
  - `out_result` = alu_result.
  - `out_store_data` = S1 rt_val.
  - `out_br_target` = pc4 + (imm << 2), modulo 2^XLEN.
  - `out_br_taken` = branch & alu_zero.
  - Control bits pass through unchanged.
- Handshake:
  - S2 advances when `out_valid` is low or `out_ready` is high.
  - S1→S2 transfer occurs when S1 is valid and S2 advances.
  - `in_ready` = !s1_valid | s1_to_s2. It is combinational and does not depend on `in_valid`.
- Flush: on the next edge, s1_valid=0 and s2_valid=0. Any input offered that cycle is discarded even though `in_ready` is high. Flush has priority over every transfer.
- Outputs hold stable while `out_valid` is high and `out_ready` is low.

## Timing
- Latency from input accept to `out_valid`: 2 cycles when unstalled.
- Throughput: 1 instruction per cycle.
- Reset (asynchronous assert, synchronous-edge release):
  - s1_valid=0, s2_valid=0.
  - All data and control registers are 0, so `alu_operation`=0000.
  - `in_ready`=1, `out_valid`=0, all `out_*`=0.
- Reset asserted mid-stall drops both entries immediately; no partial outputs.
- Simultaneous accept and transfer in the same cycle is legal: S1 is refilled while its old content moves to S2.
- Full: s1 and s2 both valid with `out_ready`=0 → `in_ready`=0.
- Empty: `out_valid`=0. The ALU outputs are ignored while s1_valid=0.

## Structure
- Shared package `mips_pkg` contains:
  - localparams for the ALU op codes.
  - The aluop encodings.
  - The funct constants.
  - A `ex_ctrl_t` struct for regwrite/memread/memwrite/branch/illegal/wreg.
- Sub-module `alu_control`: purely combinational aluop+funct → {operation, illegal}, instantiated at the S1 input.
- The ALU itself is instantiated by the parent. ex_stage only drives its inputs and reads its outputs.

## Test plan
- Accept R-type add (funct 100000), rs=5, rt=7, with `out_ready`=1 → one cycle later `alu_operation`=0010; two cycles later `out_valid`=1, `out_result`=12.
- beq with rs=rt=9, imm=3, pc4=0x100 → `alu_operation`=0110, `out_br_taken`=1, `out_br_target`=0x10C. Repeat with rt=8 → `out_br_taken`=0.
- Hold `out_ready`=0 for 4 cycles while streaming → `in_ready` falls after 2 accepts, outputs stay stable. Release → order preserved, no loss or duplication.
- Assert `flush` with both stages full and `in_valid`=1 → next cycle `out_valid`=0, s1 empty, the offered instruction never appears.
- funct 000000 with aluop 10 → `alu_operation`=0010, `out_illegal`=1. funct 100111 → 1100 (NOR). aluop 11 → 0001 (OR).
- Pulse `rst_n` low mid-stream → `out_valid` goes 0 asynchronously, `in_ready`=1, all outputs 0 before the next edge.
